// File: rtl/apb4_requester.sv
// apb4_requester: single-outstanding valid/ready command to APB4 initiator with PREADY watchdog.
module apb4_requester #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic expire, done;
  // cnt holds the number of stalled ACCESS cycles already seen, so this cycle is the TIMEOUT-th
  assign expire = (TIMEOUT != 0) && (32'(cnt) == 32'(TIMEOUT - 1)) && !PREADY;
  assign done = (state == ACCESS) && (PREADY || expire);
  assign cmd_ready = (state == IDLE) && !PRESET;
  assign rsp_valid = state == RESP;
  assign PSEL = (state == SETUP) || (state == ACCESS);
  assign PENABLE = state == ACCESS;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid ? SETUP : IDLE;
      SETUP:   state_n = ACCESS;
      ACCESS:  state_n = done ? RESP : ACCESS;
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      cnt         <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PSTRB       <= '0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (cmd_ready && cmd_valid) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PSTRB  <= cmd_write ? cmd_strb : '0;
        PWDATA <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err     <= PREADY ? PSLVERR : 1'b1;
        rsp_timeout <= !PREADY;
      end
    end
  end
endmodule

// File: tb/tb_apb4_requester.sv
// tb_apb4_requester: directed APB4 transfers with a response scoreboard and bus-phase checks.
module tb_apb4_requester;
  localparam int AW = 4, DW = 8, SW = 1, TO = 16;
  typedef struct packed {logic [DW-1:0] rdata; logic err; logic tmo;} rsp_t;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PWDATA, PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  logic [AW-1:0] nx_addr;
  logic nx_wr;
  logic [DW-1:0] nx_wdata;
  logic [SW-1:0] nx_strb;
  rsp_t sb[$];
  int total = 0, bad = 0, last_wait = 0;

  apb4_requester #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // waits < 0 means the slave never raises PREADY, so the watchdog must abort
  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input int waits, input logic [DW-1:0] rd,
                      input logic se, input int hold, input bit chain);
    int n;
    rsp_t e;
    e.tmo = waits < 0;
    e.err = e.tmo | se;
    e.rdata = (wr || e.tmo) ? '0 : rd;
    cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
    sb.push_back(e);
    n = 0;
    while (!cmd_ready && n < 20) begin tick; n++; end
    last_wait = n;
    check("cmd_ready_wait", cmd_ready, 1);
    tick;
    if (chain) begin
      cmd_addr = nx_addr; cmd_write = nx_wr; cmd_wdata = nx_wdata; cmd_strb = nx_strb;
    end else cmd_valid = 1'b0;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'hEE;
    check("setup_phase", {PSEL, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, a);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pstrb", PSTRB, wr ? st : '0);
    if (wr) check("setup_pwdata", PWDATA, wd);
    check("busy_cmd_ready", cmd_ready, 0);
    tick;
    n = waits < 0 ? TO : waits + 1;
    for (int i = 0; i < n; i++) begin
      PREADY = (i == n - 1) && waits >= 0;
      PRDATA = PREADY ? rd : DW'($urandom);
      PSLVERR = PREADY ? se : 1'b1;
      check("access_phase", {PSEL, PENABLE}, 2'b11);
      check("access_paddr", PADDR, a);
      check("access_pstrb", PSTRB, wr ? st : '0);
      check("access_cmd_ready", cmd_ready, 0);
      tick;
    end
    PREADY = 1'b1; PRDATA = 8'hFF; PSLVERR = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    check("resp_phase", {PSEL, PENABLE}, 2'b00);
    check("rsp_valid", rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, sb[0].rdata);
      check("hold_err", {rsp_err, rsp_timeout}, {sb[0].err, sb[0].tmo});
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    check("sb_nonempty", 32'(sb.size()), 1);
    e = sb.pop_front();
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_err", rsp_err, e.err);
    check("rsp_timeout", rsp_timeout, e.tmo);
    tick;
    PREADY = 1'b0; PSLVERR = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    tick; tick;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_bus", {PSEL, PENABLE, PWRITE}, 0);
    check("rst_paddr_pstrb_pwdata", {PADDR, PSTRB, PWDATA}, 0);
    PRESET = 1'b0;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    xfer(4'h4, 1'b1, 8'h5A, 1'b1, 0, 8'h77, 1'b0, 0, 1'b0);
    xfer(4'h8, 1'b0, 8'h11, 1'b1, 2, 8'hC3, 1'b0, 0, 1'b0);
    xfer(4'h2, 1'b1, 8'hA5, 1'b1, 1, 8'h00, 1'b1, 0, 1'b0);
    xfer(4'h6, 1'b0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 0, 1'b0);
    xfer(4'h1, 1'b0, 8'h00, 1'b0, 0, 8'h3C, 1'b0, 0, 1'b0);
    nx_addr = 4'h9; nx_wr = 1'b1; nx_wdata = 8'h99; nx_strb = 1'b1;
    xfer(4'h5, 1'b0, 8'h00, 1'b0, 0, 8'h5E, 1'b0, 5, 1'b1);
    xfer(nx_addr, nx_wr, nx_wdata, nx_strb, 0, 8'h00, 1'b0, 0, 1'b0);
    check("b2b_immediate_accept", last_wait, 0);
    cmd_addr = 4'h3; cmd_write = 1'b0; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    PREADY = 1'b0;
    check("rstmid_access", {PSEL, PENABLE}, 2'b11);
    tick;
    PRESET = 1'b1;
    tick;
    check("rstmid_bus", {PSEL, PENABLE}, 2'b00);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_cmd_ready", cmd_ready, 0);
    PRESET = 1'b0;
    #1;
    check("rstmid_rel_ready", cmd_ready, 1);
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rstmid_no_rsp", {rsp_valid, PSEL}, 2'b00);
    end
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
